// File: rtl/compreng_collector.sv
// Result collector for the compare engine: tracks issued searches through a fixed-latency
// delay line, captures tagged results into a small FIFO, and meters issue credit.
module compreng_collector #(
  parameter int SEGWID = 10,
  parameter int IDWID  = 8,
  parameter int TAGWID = 4,
  parameter int LAT    = 5,
  parameter int FAWID  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Issue_Valid,
  input  logic [TAGWID-1:0] i_Issue_Tag,
  output logic              o_Issue_Ready,
  input  logic [SEGWID-1:0] i_Compare_Result,
  output logic              o_Result_Valid,
  input  logic              i_Result_Ready,
  output logic [TAGWID-1:0] o_Result_Tag,
  output logic              o_Result_Hit,
  output logic              o_Result_Multi,
  output logic [IDWID-1:0]  o_Result_ID,
  input  logic              i_Clear_Stats,
  output logic [15:0]       o_Hit_Count,
  output logic [15:0]       o_Miss_Count,
  output logic              o_Overflow
);

  localparam int DEPTH = 1 << FAWID;
  localparam int EW    = TAGWID + SEGWID;
  localparam logic [FAWID:0] FULL = (FAWID+1)'(DEPTH);
  localparam logic [FAWID:0] ONE  = (FAWID+1)'(1);

  logic [LAT-1:0]    dl_vld;
  logic [TAGWID-1:0] dl_tag [LAT];
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;
  logic [FAWID-1:0]  wr_ptr, rd_ptr;
  logic [FAWID:0]    occ, outst;
  logic              accept, capture, pop;

  assign o_Issue_Ready  = (outst < FULL);
  assign o_Result_Valid = (occ != '0);
  assign accept         = i_Issue_Valid & o_Issue_Ready;
  assign capture        = dl_vld[LAT-1];
  assign pop            = o_Result_Valid & i_Result_Ready;

  assign head           = mem[rd_ptr];
  assign o_Result_Tag   = head[SEGWID +: TAGWID];
  assign o_Result_Hit   = head[SEGWID-1];
  assign o_Result_Multi = head[SEGWID-2];
  assign o_Result_ID    = head[IDWID-1:0];

  // Valids carry the tracking; tags travel alongside without reset.
  always_ff @(posedge clk) begin
    if (!rst) dl_vld <= '0;
    else      dl_vld <= {dl_vld[LAT-2:0], accept};
  end

  always_ff @(posedge clk) begin
    dl_tag[0] <= i_Issue_Tag;
    for (int i = 1; i < LAT; i++) dl_tag[i] <= dl_tag[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst && capture) mem[wr_ptr] <= {dl_tag[LAT-1], i_Compare_Result};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + FAWID'(1);
      if (pop)     rd_ptr <= rd_ptr + FAWID'(1);
      case ({capture, pop})
        2'b10:   occ <= occ + ONE;
        2'b01:   occ <= occ - ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Credit covers both in-flight and stored entries, so a capture always finds room.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outst <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outst <= outst + ONE;
        2'b01:   outst <= outst - ONE;
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                               o_Overflow <= 1'b0;
    else if (i_Issue_Valid && !o_Issue_Ready) o_Overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_Clear_Stats) begin
      o_Hit_Count  <= '0;
      o_Miss_Count <= '0;
    end else if (capture) begin
      if (i_Compare_Result[SEGWID-1]) begin
        if (o_Hit_Count != 16'hFFFF) o_Hit_Count <= o_Hit_Count + 16'd1;
      end else begin
        if (o_Miss_Count != 16'hFFFF) o_Miss_Count <= o_Miss_Count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_compreng_collector.sv
// Bench for compreng_collector: a compare-engine stand-in, a reference model of credit,
// occupancy and stats, and a scoreboard of expected results in issue order.
module tb_compreng_collector;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_Issue_Valid = 1'b0;
  logic [3:0]  i_Issue_Tag = '0;
  logic        o_Issue_Ready;
  logic [9:0]  i_Compare_Result = '0;
  logic        o_Result_Valid;
  logic        i_Result_Ready = 1'b0;
  logic [3:0]  o_Result_Tag;
  logic        o_Result_Hit;
  logic        o_Result_Multi;
  logic [7:0]  o_Result_ID;
  logic        i_Clear_Stats = 1'b0;
  logic [15:0] o_Hit_Count;
  logic [15:0] o_Miss_Count;
  logic        o_Overflow;

  compreng_collector dut (
    .clk(clk), .rst(rst),
    .i_Issue_Valid(i_Issue_Valid), .i_Issue_Tag(i_Issue_Tag), .o_Issue_Ready(o_Issue_Ready),
    .i_Compare_Result(i_Compare_Result),
    .o_Result_Valid(o_Result_Valid), .i_Result_Ready(i_Result_Ready),
    .o_Result_Tag(o_Result_Tag), .o_Result_Hit(o_Result_Hit),
    .o_Result_Multi(o_Result_Multi), .o_Result_ID(o_Result_ID),
    .i_Clear_Stats(i_Clear_Stats), .o_Hit_Count(o_Hit_Count),
    .o_Miss_Count(o_Miss_Count), .o_Overflow(o_Overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tag;
    logic [9:0] res;
  } ent_t;

  typedef struct {
    bit         iv;
    logic [3:0] tag;
    logic [9:0] res;
    bit         clr;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;
  ent_t sb[$];

  logic [9:0]  eng_res [LAT];
  bit          m_vld   [LAT];
  int          m_occ = 0;
  int          m_out = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_hit = '0;
  logic [15:0] m_miss = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit iv, input logic [3:0] tg, input logic [9:0] res,
                       input bit rdy, input bit clr);
    logic [9:0] pres;
    bit acc, cap, pp;
    ent_t e;
    pres = eng_res[LAT-1];
    i_Issue_Valid    = iv;
    i_Issue_Tag      = tg;
    i_Result_Ready   = rdy;
    i_Clear_Stats    = clr;
    i_Compare_Result = pres;
    #1;
    chk("issue_ready", o_Issue_Ready, m_out < 8);
    chk("result_valid", o_Result_Valid, m_occ != 0);
    chk("overflow", o_Overflow, m_ovf);
    chk("hit_count", o_Hit_Count, m_hit);
    chk("miss_count", o_Miss_Count, m_miss);
    if (o_Result_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("head_unexpected", 1, 0);
      end else begin
        e = sb[0];
        chk("head_tag", o_Result_Tag, e.tag);
        chk("head_hit", o_Result_Hit, e.res[9]);
        chk("head_multi", o_Result_Multi, e.res[8]);
        chk("head_id", o_Result_ID, e.res[7:0]);
      end
    end
    if (!rst) begin
      for (int k = 0; k < LAT; k++) m_vld[k] = 1'b0;
      m_occ = 0; m_out = 0; m_ovf = 1'b0; m_hit = '0; m_miss = '0;
      sb.delete();
    end else begin
      acc = iv && (m_out < 8);
      cap = m_vld[LAT-1];
      pp  = (m_occ != 0) && rdy;
      if (iv && !(m_out < 8)) m_ovf = 1'b1;
      if (clr) begin
        m_hit = '0; m_miss = '0;
      end else if (cap) begin
        if (pres[9]) begin if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1; end
        else begin if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1; end
      end
      if (cap) m_occ++;
      if (pp) begin m_occ--; n_pop++; void'(sb.pop_front()); end
      if (acc) begin m_out++; sb.push_back('{tag: tg, res: res}); end
      if (pp) m_out--;
      for (int k = LAT-1; k > 0; k--) m_vld[k] = m_vld[k-1];
      m_vld[0] = acc;
    end
    for (int k = LAT-1; k > 0; k--) eng_res[k] = eng_res[k-1];
    eng_res[0] = iv ? res : 10'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle(1'b0, 4'd0, 10'd0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 10'd0, rdy, 1'b0);
  endtask

  function automatic vec_t mk(bit iv, logic [9:0] res, bit clr, logic [15:0] h, logic [15:0] m);
    vec_t v;
    v.iv = iv; v.tag = 4'(res[3:0]); v.res = res; v.clr = clr; v.exp_hit = h; v.exp_miss = m;
    return v;
  endfunction

  initial begin
    vec_t tbl[17];
    int   p0;
    logic [9:0] r;

    tbl[0]  = mk(1, 10'h211, 0, 0, 0);
    tbl[1]  = mk(1, 10'h302, 0, 0, 0);
    tbl[2]  = mk(1, 10'h033, 0, 0, 0);
    tbl[3]  = mk(1, 10'h244, 0, 0, 0);
    tbl[4]  = mk(1, 10'h155, 0, 0, 0);
    tbl[5]  = mk(0, 10'h000, 0, 0, 0);
    tbl[6]  = mk(0, 10'h000, 0, 1, 0);
    tbl[7]  = mk(0, 10'h000, 0, 2, 0);
    tbl[8]  = mk(0, 10'h000, 0, 2, 1);
    tbl[9]  = mk(0, 10'h000, 0, 3, 1);
    tbl[10] = mk(1, 10'h266, 0, 3, 2);
    tbl[11] = mk(0, 10'h000, 0, 3, 2);
    tbl[12] = mk(0, 10'h000, 0, 3, 2);
    tbl[13] = mk(0, 10'h000, 0, 3, 2);
    tbl[14] = mk(0, 10'h000, 0, 3, 2);
    tbl[15] = mk(0, 10'h000, 1, 3, 2);
    tbl[16] = mk(0, 10'h000, 0, 0, 0);

    for (int k = 0; k < LAT; k++) begin eng_res[k] = '0; m_vld[k] = 1'b0; end
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_valid", o_Result_Valid, 0);
    chk("rst_ready", o_Issue_Ready, 1);
    chk("rst_hits", o_Hit_Count, 0);
    chk("rst_misses", o_Miss_Count, 0);
    chk("rst_overflow", o_Overflow, 0);

    // Single search
    idle(3, 1'b0);
    cycle(1'b1, 4'd3, 10'h2A5, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("single_not_early", o_Result_Valid, 0);
    idle(1, 1'b0);
    chk("single_valid", o_Result_Valid, 1);
    chk("single_tag", o_Result_Tag, 3);
    chk("single_hit", o_Result_Hit, 1);
    chk("single_multi", o_Result_Multi, 0);
    chk("single_id", o_Result_ID, 8'hA5);
    idle(1, 1'b1);
    chk("single_hitcount", o_Hit_Count, 1);
    chk("single_drained", o_Result_Valid, 0);

    // Backpressure and credit
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      r = 10'($urandom);
      cycle(1'b1, 4'(i), r, 1'b0, 1'b0);
      if (i == 7) chk("bp_ready_low", o_Issue_Ready, 0);
    end
    chk("bp_overflow", o_Overflow, 1);
    idle(6, 1'b0);
    chk("bp_stored_valid", o_Result_Valid, 1);
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1, 1'b1);
    chk("bp_pops", n_pop - p0, 8);
    chk("bp_empty", o_Result_Valid, 0);
    chk("bp_ready_back", o_Issue_Ready, 1);

    // Streaming
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      r = 10'($urandom);
      cycle(1'b1, 4'(i), r, 1'b1, 1'b0);
    end
    idle(LAT + 3, 1'b1);
    chk("stream_pops", n_pop - p0, 100);
    chk("stream_overflow", o_Overflow, 0);
    chk("stream_sb_empty", sb.size(), 0);

    // Stats with clear colliding with a capture
    do_reset();
    for (int i = 0; i < 17; i++) begin
      chk("tbl_hits", o_Hit_Count, tbl[i].exp_hit);
      chk("tbl_misses", o_Miss_Count, tbl[i].exp_miss);
      cycle(tbl[i].iv, tbl[i].tag, tbl[i].res, 1'b1, tbl[i].clr);
    end

    // Reset mid-flight: 2 stored, 4 in flight
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 8), 10'h300 | 10'(i), 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("mid_stored", o_Result_Valid, 1);
    do_reset();
    for (int k = 0; k < LAT + 2; k++) begin
      chk("mid_no_result", o_Result_Valid, 0);
      chk("mid_ready", o_Issue_Ready, 1);
      idle(1, 1'b1);
    end
    chk("mid_hits", o_Hit_Count, 0);

    // Capture and pop together at occupancy 1
    do_reset();
    cycle(1'b1, 4'd5, 10'h105, 1'b0, 1'b0);
    cycle(1'b1, 4'd6, 10'h206, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("cp_head_a", o_Result_Tag, 5);
    idle(1, 1'b1);
    chk("cp_valid", o_Result_Valid, 1);
    chk("cp_head_b", o_Result_Tag, 6);
    chk("cp_id_b", o_Result_ID, 8'h06);
    idle(1, 1'b1);
    chk("cp_empty", o_Result_Valid, 0);

    // Hit counter saturation
    do_reset();
    for (int i = 0; i < 65536; i++) cycle(1'b1, 4'(i), 10'h200 | 10'(i & 255), 1'b1, 1'b0);
    idle(LAT + 3, 1'b1);
    chk("sat_hits", o_Hit_Count, 16'hFFFF);
    chk("sat_misses", o_Miss_Count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
